// File: rtl/exec_pkg.sv
// Shared constants for the RV32I integer execute unit.
// ALUOp classes, ALU op codes and branch funct3 values.
package exec_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] ALUOP_ADD    = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ITYPE  = 3'b011;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALU_AND  = 4'b0000;
  localparam alu_op_t ALU_OR   = 4'b0001;
  localparam alu_op_t ALU_ADD  = 4'b0010;
  localparam alu_op_t ALU_XOR  = 4'b0011;
  localparam alu_op_t ALU_SLL  = 4'b0100;
  localparam alu_op_t ALU_SRL  = 4'b0101;
  localparam alu_op_t ALU_SUB  = 4'b0110;
  localparam alu_op_t ALU_SRA  = 4'b0111;
  localparam alu_op_t ALU_SLT  = 4'b1000;
  localparam alu_op_t ALU_SLTU = 4'b1001;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/exec_alu_core.sv
// Integer ALU datapath: op, A, B -> result and zero flag.
// Unassigned op codes produce a zero result.
module exec_alu_core
  import exec_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  alu_op_t          op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic [XLEN-1:0]  rc,
  output logic             z
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;

  assign shamt = b[SHW-1:0];

  always_comb begin
    rc = '0;
    unique case (op)
      ALU_AND:  rc = a & b;
      ALU_OR:   rc = a | b;
      ALU_ADD:  rc = a + b;
      ALU_XOR:  rc = a ^ b;
      ALU_SLL:  rc = a << shamt;
      ALU_SRL:  rc = a >> shamt;
      ALU_SUB:  rc = a - b;
      ALU_SRA:  rc = $signed(a) >>> shamt;
      ALU_SLT:  rc = {{(XLEN-1){1'b0}},
                      $signed(a) < $signed(b)};
      ALU_SLTU: rc = {{(XLEN-1){1'b0}}, a < b};
      default:  rc = '0;
    endcase
  end

  assign z = ~|rc;

endmodule

// File: rtl/exec_alu_branch_unit.sv
// Execute unit: ALU-op decode, integer ALU and branch resolution.
// REG_OUT=1 registers every output behind a synchronous active-low reset.
module exec_alu_branch_unit
  import exec_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter bit REG_OUT = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [2:0]      i_ALUOp,
  input  logic [2:0]      i_Funct3,
  input  logic [6:0]      i_Funct7,
  input  logic            i_Branch,
  input  logic [XLEN-1:0] i_Ra,
  input  logic [XLEN-1:0] i_Rb,
  output logic [3:0]      o_ALUControlLines,
  output logic [XLEN-1:0] o_Rc,
  output logic            o_Z,
  output logic            o_DoBranch
);

  alu_op_t         ctrl;
  logic [XLEN-1:0] rc;
  logic            z;
  logic            cond;
  logic            take;
  logic            f7b5;
  logic            unused_f7;

  assign f7b5      = i_Funct7[5];
  assign unused_f7 = ^{i_Funct7[6], i_Funct7[4:0]};

  always_comb begin
    ctrl = ALU_ADD;
    unique case (i_ALUOp)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        unique case (1'b1)
          ~i_Funct3[2]:               ctrl = ALU_SUB;
          i_Funct3[2] & ~i_Funct3[1]: ctrl = ALU_SLT;
          i_Funct3[2] &  i_Funct3[1]: ctrl = ALU_SLTU;
        endcase
      end
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        unique case (i_Funct3)
          3'b000: ctrl = (i_ALUOp == ALUOP_RTYPE && f7b5)
                         ? ALU_SUB : ALU_ADD;
          3'b001: ctrl = ALU_SLL;
          3'b010: ctrl = ALU_SLT;
          3'b011: ctrl = ALU_SLTU;
          3'b100: ctrl = ALU_XOR;
          3'b101: ctrl = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110: ctrl = ALU_OR;
          3'b111: ctrl = ALU_AND;
        endcase
      end
      default: ctrl = ALU_ADD;
    endcase
  end

  exec_alu_core #(
    .XLEN (XLEN)
  ) u_alu (
    .op (ctrl),
    .a  (i_Ra),
    .b  (i_Rb),
    .rc (rc),
    .z  (z)
  );

  // SLT/SLTU result bit 0 carries the less-than outcome
  always_comb begin
    cond = 1'b0;
    unique case (i_Funct3)
      F3_BEQ:           cond = z;
      F3_BNE:           cond = ~z;
      F3_BLT, F3_BLTU:  cond = rc[0];
      F3_BGE, F3_BGEU:  cond = ~rc[0];
      default:          cond = 1'b0;
    endcase
  end

  assign take = i_Branch & cond;

  if (REG_OUT) begin : g_reg
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        o_ALUControlLines <= '0;
        o_Rc              <= '0;
        o_Z               <= 1'b0;
        o_DoBranch        <= 1'b0;
      end else begin
        o_ALUControlLines <= ctrl;
        o_Rc              <= rc;
        o_Z               <= z;
        o_DoBranch        <= take;
      end
    end
  end else begin : g_comb
    logic unused_clk;
    assign unused_clk        = i_clk ^ i_rst;
    assign o_ALUControlLines = ctrl;
    assign o_Rc              = rc;
    assign o_Z               = z;
    assign o_DoBranch        = take;
  end

endmodule

// File: tb/tb_exec_alu_branch_unit.sv
// Bench for exec_alu_branch_unit: combinational and registered builds
// checked against a behavioural model of the RV32I execute rules.
module tb_exec_alu_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  aluop;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        br;
  logic [31:0] ra;
  logic [31:0] rb;

  logic [3:0]  ctrl0, ctrl1;
  logic [31:0] rc0, rc1;
  logic        z0, z1, br0, br1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exec_alu_branch_unit #(.XLEN(32), .REG_OUT(1'b0)) dut0 (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ALUOp           (aluop),
    .i_Funct3          (f3),
    .i_Funct7          (f7),
    .i_Branch          (br),
    .i_Ra              (ra),
    .i_Rb              (rb),
    .o_ALUControlLines (ctrl0),
    .o_Rc              (rc0),
    .o_Z               (z0),
    .o_DoBranch        (br0)
  );

  exec_alu_branch_unit #(.XLEN(32), .REG_OUT(1'b1)) dut1 (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_ALUOp           (aluop),
    .i_Funct3          (f3),
    .i_Funct7          (f7),
    .i_Branch          (br),
    .i_Ra              (ra),
    .i_Rb              (rb),
    .o_ALUControlLines (ctrl1),
    .o_Rc              (rc1),
    .o_Z               (z1),
    .o_DoBranch        (br1)
  );

  function automatic logic [3:0] m_ctrl(input logic [2:0] op,
                                        input logic [2:0] fn3,
                                        input logic [6:0] fn7);
    if (op == 3'b001) begin
      if (fn3 == 3'b100 || fn3 == 3'b101) return 4'b1000;
      if (fn3 == 3'b110 || fn3 == 3'b111) return 4'b1001;
      return 4'b0110;
    end
    if (op == 3'b010 || op == 3'b011) begin
      case (fn3)
        3'b000: return (op == 3'b010 && fn7[5]) ? 4'b0110 : 4'b0010;
        3'b001: return 4'b0100;
        3'b010: return 4'b1000;
        3'b011: return 4'b1001;
        3'b100: return 4'b0011;
        3'b101: return fn7[5] ? 4'b0111 : 4'b0101;
        3'b110: return 4'b0001;
        default: return 4'b0000;
      endcase
    end
    return 4'b0010;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] c,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    int sa;
    longint sx;
    sa = int'(b % 32);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'b0011: return a ^ b;
      4'b0100: return 32'(64'(a) * (64'd1 << sa));
      4'b0101: return 32'(64'(a) / (64'd1 << sa));
      4'b0110: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b))
                          % 64'h1_0000_0000);
      4'b0111: begin
        sx = longint'($signed(a));
        for (int k = 0; k < sa; k++) sx = (sx - (sx & 1)) / 2;
        return 32'(sx);
      end
      4'b1000: return (int'($signed(a)) < int'($signed(b))) ? 1 : 0;
      4'b1001: return (64'(a) < 64'(b)) ? 1 : 0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_br(input logic b, input logic [2:0] fn3,
                                input logic [31:0] r);
    if (!b) return 1'b0;
    case (fn3)
      3'b000: return r == 0;
      3'b001: return r != 0;
      3'b100, 3'b110: return r[0];
      3'b101, 3'b111: return !r[0];
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [2:0] op, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic b,
                       input logic [31:0] a, input logic [31:0] bb);
    logic [3:0]  ec;
    logic [31:0] er;
    logic        eb;
    aluop = op; f3 = fn3; f7 = fn7; br = b; ra = a; rb = bb;
    ec = m_ctrl(op, fn3, fn7);
    er = m_alu(ec, a, bb);
    eb = m_br(b, fn3, er);
    #1;
    chk("ctrl", 32'(ctrl0), 32'(ec));
    chk("rc", rc0, er);
    chk("z", 32'(z0), 32'(er == 0));
    chk("br", 32'(br0), 32'(eb));
    @(posedge clk); #1;
    chk("r_ctrl", 32'(ctrl1), 32'(ec));
    chk("r_rc", rc1, er);
    chk("r_z", 32'(z1), 32'(er == 0));
    chk("r_br", 32'(br1), 32'(eb));
  endtask

  task automatic chk_reset();
    chk("rst_ctrl", 32'(ctrl1), 32'd0);
    chk("rst_rc", rc1, 32'd0);
    chk("rst_z", 32'(z1), 32'd0);
    chk("rst_br", 32'(br1), 32'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    rst = 1'b0;
    aluop = 3'b001; f3 = 3'b000; f7 = 7'h00; br = 1'b1;
    ra = 32'h1234; rb = 32'h1234;
    @(posedge clk); #1;
    chk_reset();
    rst = 1'b1;

    apply(3'b010, 3'b000, 7'b0100000, 1'b0, 32'd5, 32'd7);
    chk("plan_sub", rc0, 32'hFFFF_FFFE);
    apply(3'b010, 3'b000, 7'b0000000, 1'b0, 32'd5, 32'd7);
    chk("plan_add", rc0, 32'd12);
    apply(3'b011, 3'b000, 7'b0100000, 1'b0, 32'd10, 32'hFFFF_FFFF);
    chk("plan_iadd", rc0, 32'd9);
    apply(3'b011, 3'b101, 7'b0100000, 1'b0, 32'h8000_0000, 32'd4);
    chk("plan_sra", rc0, 32'hF800_0000);
    apply(3'b011, 3'b101, 7'b0000000, 1'b0, 32'h8000_0000, 32'd4);
    chk("plan_srl", rc0, 32'h0800_0000);
    apply(3'b010, 3'b010, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("plan_slt", rc0, 32'd1);
    apply(3'b010, 3'b011, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1);
    chk("plan_sltu_z", 32'(z0), 32'd1);
    apply(3'b001, 3'b000, 7'h00, 1'b1, 32'h1234, 32'h1234);
    chk("plan_beq", 32'(br0), 32'd1);
    apply(3'b001, 3'b001, 7'h00, 1'b1, 32'h1234, 32'h1234);
    chk("plan_bne", 32'(br0), 32'd0);
    apply(3'b001, 3'b101, 7'h00, 1'b1, 32'hFFFF_FFFD, 32'd2);
    chk("plan_bge", 32'(br0), 32'd0);
    apply(3'b001, 3'b110, 7'h00, 1'b1, 32'd2, 32'hFFFF_FFFE);
    chk("plan_bltu", 32'(br0), 32'd1);
    apply(3'b001, 3'b010, 7'h00, 1'b1, 32'd2, 32'd2);
    chk("plan_f3_010", 32'(br0), 32'd0);
    apply(3'b001, 3'b000, 7'h00, 1'b0, 32'h1234, 32'h1234);
    chk("plan_nobr", 32'(br0), 32'd0);
    apply(3'b010, 3'b001, 7'h00, 1'b0, 32'd1, 32'h21);
    chk("plan_sll", rc0, 32'd2);
    apply(3'b100, 3'b111, 7'h7F, 1'b0, 32'd3, 32'd4);
    chk("plan_reg_add", rc1, 32'd7);

    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset();
    rst = 1'b1;

    for (int i = 0; i < 400; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 63);
      apply(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            7'($urandom), 1'($urandom), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exec_alu_branch_unit.md
Name: exec_alu_branch_unit

Overview:
- Integer execute unit for the single-cycle RV32I datapath.
- Combines three functions:
  - ALU-op decode from main-control ALUOp, funct3 and funct7.
  - 32-bit integer ALU with zero flag.
  - Branch-condition resolution producing the taken signal for the PC mux.
- Sits between register-file/immediate operand muxes and the PC/write-back/data-memory-address logic.

Parameters:
- XLEN, 32, datapath width.
- REG_OUT, 0, 0 = all outputs combinational; 1 = all outputs registered (one-cycle latency).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_ALUOp  in  3  operation class from main control
- i_Funct3  in  3  instr[14:12]
- i_Funct7  in  7  instr[31:25]; only bit 5 is significant
- i_Branch  in  1  instruction is a conditional branch
- i_Ra  in  XLEN  operand A (rs1, PC or 0)
- i_Rb  in  XLEN  operand B (rs2 or immediate)
- o_ALUControlLines  out  4  decoded ALU operation
- o_Rc  out  XLEN  ALU result
- o_Z  out  1  high when o_Rc == 0
- o_DoBranch  out  1  branch taken

Behaviour:
- Clock and reset: i_clk and i_rst used only when REG_OUT=1; otherwise unused and outputs are pure combinational functions of the inputs.
- REG_OUT=1:
  - All four outputs registered on posedge i_clk.
  - i_rst low at a clock edge: all outputs return to 0, ALUControlLines 0000, regardless of inputs; reset mid-operation discards the in-flight result.
- ALU control encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SRA 0111, SLT 1000, SLTU 1001; codes 1010-1111 yield o_Rc=0.
- ALUOp decode:
  - 000 (load/store/AUIPC/JAL/LUI address): ADD.
  - 001 (branch): funct3 000/001 -> SUB; 100/101 -> SLT; 110/111 -> SLTU; 010/011 -> SUB.
  - 010 (R-type), by funct3:
    - 000: SUB if funct7[5] else ADD
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7[5] else SRL
    - 110: OR
    - 111: AND
  - 011 (I-type arith): same as R-type except funct3 000 is always ADD (funct7 ignored); funct7[5] still selects SRA/SRL for 101.
  - 100-111: ADD.
- Arithmetic:
  - ADD/SUB modulo 2^XLEN; no overflow flag.
  - Shifts use i_Rb[4:0] only; SRA sign-fills from i_Ra[31].
  - SLT signed compare, SLTU unsigned; result is 0 or 1 zero-extended.
- o_Z = ~|o_Rc, for every operation.
- Branch resolution, o_DoBranch = i_Branch AND cond(funct3):
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: Rc[0]
  - 101 BGE: !Rc[0]
  - 110 BLTU: Rc[0]
  - 111 BGEU: !Rc[0]
  - 010/011: 0
  - i_Branch=0 forces 0 independent of the ALU result.
- No internal state other than the REG_OUT output registers; no X propagation from unused opcode combinations (defaults above are mandatory).

Decomposition:
- Shared package exec_pkg holds:
  - XLEN default.
  - ALUOp class constants (ALUOP_ADD, ALUOP_BRANCH, ALUOP_RTYPE, ALUOP_ITYPE).
  - 4-bit ALU op constants (ALU_AND ... ALU_SLTU).
  - funct3 branch constants.
- One natural sub-module: exec_alu_core, the datapath ALU (op, A, B -> result, Z).
- Decode and branch logic stay in the top module.

Test Plan:
- R-type: ALUOp=010, f3=000, f7=0100000, Ra=5, Rb=7 -> ctrl 0110, Rc=0xFFFFFFFE, Z=0; f7=0 -> ctrl 0010, Rc=12.
- I-type: ALUOp=011, f3=000, f7=0100000, Ra=10, Rb=0xFFFFFFFF -> ctrl 0010 (ADD), Rc=9; f3=101, f7=0100000, Ra=0x80000000, Rb=4 -> Rc=0xF8000000; f7=0 -> Rc=0x08000000.
- SLT/SLTU: Ra=0xFFFFFFFF, Rb=1: SLT -> Rc=1; SLTU -> Rc=0, Z=1.
- Branches with i_Branch=1, ALUOp=001:
  - BEQ, Ra=Rb=0x1234 -> DoBranch=1.
  - BNE, same operands -> 0.
  - BGE, Ra=-3, Rb=2 -> 0.
  - BLTU, Ra=2, Rb=0xFFFFFFFE -> 1.
  - f3=010 -> 0.
  - i_Branch=0 with BEQ-equal operands -> 0.
- Shift masking: SLL, Ra=1, Rb=0x00000021 -> Rc=2.
- REG_OUT=1:
  - ADD 3+4 applied -> Rc=7 one edge later.
  - i_rst=0 at next edge -> Rc=0, Z=0, DoBranch=0, ctrl=0000 after that edge.
